// File: rtl/msp_requester.sv
// msp_requester: MSP v1 master-side requester.
// Serialises a request frame ($M< len cmd payload crc) onto a byte-parallel
// UART transmit interface, then parses the reply frame ($M> or $M!) from the
// receive byte stream. Reply payload bytes are forwarded as they arrive, and
// the transaction closes with a single completion pulse carrying cmd, len and
// status.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     request handshake, with req_cmd and req_len (8b each)
//   req_pl_data/valid/  request payload byte stream (taken in TX_PAYLOAD)
//   req_pl_ready
//   tx_data/valid/ready UART transmit byte interface
//   rx_data/valid       UART receive byte strobe (no backpressure)
//   rsp_data/           reply payload byte, one-cycle strobe per byte
//   rsp_data_valid
//   rsp_valid, rsp_cmd, completion pulse with reply cmd, len and status
//   rsp_len, rsp_status (0 ok, 1 crc/length error, 2 remote error, 3 timeout)
//   busy                high whenever the block is not idle
module msp_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 72_000_000 / 100,
  parameter int unsigned MAX_RSP_LEN    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_len,
  input  logic [7:0] req_pl_data,
  input  logic       req_pl_valid,
  output logic       req_pl_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_data_valid,
  output logic       rsp_valid,
  output logic [7:0] rsp_cmd,
  output logic [7:0] rsp_len,
  output logic [1:0] rsp_status,
  output logic       busy
);

  localparam int unsigned BW = 8;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [BW-1:0] CH_DOLLAR = 8'h24;
  localparam logic [BW-1:0] CH_M      = 8'h4D;
  localparam logic [BW-1:0] CH_TO_FC  = 8'h3C;
  localparam logic [BW-1:0] CH_FROM_FC = 8'h3E;
  localparam logic [BW-1:0] CH_ERR    = 8'h21;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_CRC_ERR = 2'd1;
  localparam logic [1:0] ST_REMOTE  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [3:0] {
    IDLE,
    TX_DOLLAR,
    TX_M,
    TX_DIR,
    TX_LEN,
    TX_CMD,
    TX_PAYLOAD,
    TX_CRC,
    RX_DOLLAR,
    RX_M,
    RX_DIR,
    RX_LEN,
    RX_CMD,
    RX_PAYLOAD,
    RX_CRC,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   cmd_q, cmd_d;
  logic [BW-1:0]   len_q, len_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   crc_q, crc_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [BW-1:0]   tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic [BW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_data_valid_q, rsp_data_valid_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [BW-1:0]   rsp_cmd_q, rsp_cmd_d;
  logic [BW-1:0]   rsp_len_q, rsp_len_d;
  logic [1:0]      rsp_status_q, rsp_status_d;

  logic            tx_load;
  logic            rx_state;
  logic [BW-1:0]   cnt_inc;

  // A new TX byte may only be loaded into an empty holding register.
  assign tx_load  = tx_ready && !tx_valid_q;
  assign rx_state = (state_q == RX_DOLLAR) || (state_q == RX_M) ||
                    (state_q == RX_DIR)    || (state_q == RX_LEN) ||
                    (state_q == RX_CMD)    || (state_q == RX_PAYLOAD) ||
                    (state_q == RX_CRC);
  assign cnt_inc  = cnt_q + BW'(1);

  assign req_ready      = (state_q == IDLE);
  assign req_pl_ready   = (state_q == TX_PAYLOAD) && tx_load;
  assign busy           = (state_q != IDLE);
  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_data_valid = rsp_data_valid_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_cmd        = rsp_cmd_q;
  assign rsp_len        = rsp_len_q;
  assign rsp_status     = rsp_status_q;

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      cmd_q            <= '0;
      len_q            <= '0;
      cnt_q            <= '0;
      crc_q            <= '0;
      err_q            <= 1'b0;
      timer_q          <= '0;
      tx_data_q        <= '0;
      tx_valid_q       <= 1'b0;
      rsp_data_q       <= '0;
      rsp_data_valid_q <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_cmd_q        <= '0;
      rsp_len_q        <= '0;
      rsp_status_q     <= '0;
    end else begin
      state_q          <= state_d;
      cmd_q            <= cmd_d;
      len_q            <= len_d;
      cnt_q            <= cnt_d;
      crc_q            <= crc_d;
      err_q            <= err_d;
      timer_q          <= timer_d;
      tx_data_q        <= tx_data_d;
      tx_valid_q       <= tx_valid_d;
      rsp_data_q       <= rsp_data_d;
      rsp_data_valid_q <= rsp_data_valid_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_cmd_q        <= rsp_cmd_d;
      rsp_len_q        <= rsp_len_d;
      rsp_status_q     <= rsp_status_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d          = state_q;
    cmd_d            = cmd_q;
    len_d            = len_q;
    cnt_d            = cnt_q;
    crc_d            = crc_q;
    err_d            = err_q;
    timer_d          = '0;
    tx_data_d        = tx_data_q;
    tx_valid_d       = tx_valid_q;
    rsp_data_d       = rsp_data_q;
    rsp_data_valid_d = 1'b0;
    rsp_valid_d      = 1'b0;
    rsp_cmd_d        = rsp_cmd_q;
    rsp_len_d        = rsp_len_q;
    rsp_status_d     = rsp_status_q;

    // Holding register empties on handshake, in any state (the crc byte
    // drains while the receiver is already listening).
    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cmd_d   = req_cmd;
          len_d   = req_len;
          state_d = TX_DOLLAR;
        end
      end
      TX_DOLLAR: begin
        if (tx_load) begin
          tx_data_d  = CH_DOLLAR;
          tx_valid_d = 1'b1;
          state_d    = TX_M;
        end
      end
      TX_M: begin
        if (tx_load) begin
          tx_data_d  = CH_M;
          tx_valid_d = 1'b1;
          state_d    = TX_DIR;
        end
      end
      TX_DIR: begin
        if (tx_load) begin
          tx_data_d  = CH_TO_FC;
          tx_valid_d = 1'b1;
          state_d    = TX_LEN;
        end
      end
      TX_LEN: begin
        if (tx_load) begin
          tx_data_d  = len_q;
          tx_valid_d = 1'b1;
          crc_d      = len_q;
          state_d    = TX_CMD;
        end
      end
      TX_CMD: begin
        if (tx_load) begin
          tx_data_d  = cmd_q;
          tx_valid_d = 1'b1;
          crc_d      = crc_q ^ cmd_q;
          cnt_d      = '0;
          state_d    = (len_q == '0) ? TX_CRC : TX_PAYLOAD;
        end
      end
      TX_PAYLOAD: begin
        if (tx_load && req_pl_valid) begin
          tx_data_d  = req_pl_data;
          tx_valid_d = 1'b1;
          crc_d      = crc_q ^ req_pl_data;
          cnt_d      = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = TX_CRC;
          end
        end
      end
      TX_CRC: begin
        if (tx_load) begin
          tx_data_d  = crc_q;
          tx_valid_d = 1'b1;
          state_d    = RX_DOLLAR;
        end
      end
      RX_DOLLAR: begin
        if (rx_valid && (rx_data == CH_DOLLAR)) begin
          state_d = RX_M;
        end
      end
      RX_M: begin
        if (rx_valid) begin
          state_d = (rx_data == CH_M) ? RX_DIR : RX_DOLLAR;
        end
      end
      RX_DIR: begin
        if (rx_valid) begin
          if (rx_data == CH_FROM_FC) begin
            err_d   = 1'b0;
            state_d = RX_LEN;
          end else if (rx_data == CH_ERR) begin
            err_d   = 1'b1;
            state_d = RX_LEN;
          end else begin
            state_d = RX_DOLLAR;
          end
        end
      end
      RX_LEN: begin
        if (rx_valid) begin
          rsp_len_d = rx_data;
          crc_d     = rx_data;
          // Oversized replies are rejected before any payload is forwarded.
          if (32'(rx_data) > MAX_RSP_LEN) begin
            rsp_status_d = ST_CRC_ERR;
            rsp_valid_d  = 1'b1;
            state_d      = DONE;
          end else begin
            state_d = RX_CMD;
          end
        end
      end
      RX_CMD: begin
        if (rx_valid) begin
          rsp_cmd_d = rx_data;
          crc_d     = crc_q ^ rx_data;
          cnt_d     = '0;
          state_d   = (rsp_len_q == '0) ? RX_CRC : RX_PAYLOAD;
        end
      end
      RX_PAYLOAD: begin
        if (rx_valid) begin
          rsp_data_d       = rx_data;
          rsp_data_valid_d = 1'b1;
          crc_d            = crc_q ^ rx_data;
          cnt_d            = cnt_inc;
          if (cnt_inc == rsp_len_q) begin
            state_d = RX_CRC;
          end
        end
      end
      RX_CRC: begin
        if (rx_valid) begin
          if (rx_data != crc_q) begin
            rsp_status_d = ST_CRC_ERR;
          end else begin
            rsp_status_d = err_q ? ST_REMOTE : ST_OK;
          end
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reply timeout: counts idle cycles while receiving, any byte restarts it.
    if (rx_state && !rx_valid) begin
      if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        rsp_status_d = ST_TIMEOUT;
        rsp_valid_d  = 1'b1;
        state_d      = DONE;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

endmodule
